// File: rtl/qft_seq_ctrl.sv
// Multi-row MULT/ACC sequencer for the signed QFT datapath, with start/busy/done, stall and abort.
// Optional magnitude pass (ABS/ABS_END) is built only when QFT_SEQ_ABS_EN is defined.
module qft_seq_ctrl #(
  parameter int N        = 4,
  parameter int ROWS     = 4,
  parameter int MULT_LAT = 1,
  localparam int WIDTH   = $clog2(N),
  localparam int RW      = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             strt_qft,
  input  logic             strt_abs,
  input  logic             abort,
  input  logic [WIDTH:0]   n_terms,
  input  logic             mult_ready,
  output logic             w_en_mult,
  output logic             w_en_acc,
  output logic             clr_acc,
  output logic             w_en_abs,
  output logic             update_state,
  output logic [WIDTH:0]   sel_counter,
  output logic [RW-1:0]    row_idx,
  output logic             busy,
  output logic             done
);

  localparam int LW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
  localparam logic [WIDTH:0] N_W     = (WIDTH+1)'(N);
  localparam logic [WIDTH:0] ONE_W   = (WIDTH+1)'(1);
  localparam logic [LW-1:0]  LAT_MAX = LW'(MULT_LAT - 1);
  localparam logic [LW-1:0]  LAT_ONE = LW'(1);
  localparam logic [RW-1:0]  ROW_MAX = RW'(ROWS - 1);
  localparam logic [RW-1:0]  ROW_ONE = RW'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_MULT    = 3'd2,
    S_ACC     = 3'd3,
    S_ROW_END = 3'd4
`ifdef QFT_SEQ_ABS_EN
    ,
    S_ABS     = 3'd5,
    S_ABS_END = 3'd6
`endif
  } state_t;

  state_t          state, state_nxt;
  logic [WIDTH:0]  len;
  logic [LW-1:0]   lat_cnt;
  logic [WIDTH:0]  sel_inc;
  logic            lat_last;
  logic            last_row;
  logic            kill;

  // sel_counter never exceeds N-1, so the increment cannot wrap in WIDTH+1 bits
  assign sel_inc  = sel_counter + ONE_W;
  assign lat_last = (lat_cnt == LAT_MAX);
  assign last_row = (row_idx == ROW_MAX);
  assign kill     = abort && (state != S_IDLE);

`ifndef QFT_SEQ_ABS_EN
  logic unused_strt_abs;
  assign unused_strt_abs = strt_abs;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next-state logic; abort overrides every pending transition
  always_comb begin
    state_nxt = state;
    if (kill) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (strt_qft) state_nxt = S_LOAD;
`ifdef QFT_SEQ_ABS_EN
          else if (strt_abs) state_nxt = S_ABS;
`endif
        end
        S_LOAD:    state_nxt = S_MULT;
        S_MULT:    if (lat_last && mult_ready) state_nxt = S_ACC;
        S_ACC:     state_nxt = (sel_inc < len) ? S_MULT : S_ROW_END;
        S_ROW_END: state_nxt = last_row ? S_IDLE : S_LOAD;
`ifdef QFT_SEQ_ABS_EN
        S_ABS:     if (last_row) state_nxt = S_ABS_END;
        S_ABS_END: state_nxt = S_IDLE;
`endif
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  // output decode: pure function of state/counters, commit pulses masked by abort
  always_comb begin
    w_en_mult    = 1'b0;
    w_en_acc     = 1'b0;
    clr_acc      = 1'b0;
    w_en_abs     = 1'b0;
    update_state = 1'b0;
    done         = 1'b0;
    busy         = (state != S_IDLE);
    case (state)
      S_LOAD:    clr_acc   = 1'b1;
      S_MULT:    w_en_mult = 1'b1;
      S_ACC:     w_en_acc  = 1'b1;
      S_ROW_END: begin
        update_state = !abort;
        done         = !abort && last_row;
      end
`ifdef QFT_SEQ_ABS_EN
      S_ABS:     w_en_abs = 1'b1;
      S_ABS_END: begin
        update_state = !abort;
        done         = !abort;
      end
`endif
      default: ;
    endcase
  end

  // term, row and latency counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len         <= N_W;
      sel_counter <= '0;
      row_idx     <= '0;
      lat_cnt     <= '0;
    end else if (kill) begin
      sel_counter <= '0;
      row_idx     <= '0;
      lat_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          sel_counter <= '0;
          row_idx     <= '0;
          lat_cnt     <= '0;
        end
        S_LOAD: begin
          len         <= (n_terms == '0 || n_terms > N_W) ? N_W : n_terms;
          sel_counter <= '0;
        end
        S_MULT: begin
          if (lat_last && mult_ready) lat_cnt <= '0;
          else if (!lat_last)         lat_cnt <= lat_cnt + LAT_ONE;
        end
        S_ACC: begin
          if (sel_inc < len) sel_counter <= sel_inc;
        end
        S_ROW_END: begin
          sel_counter <= '0;
          row_idx     <= last_row ? '0 : row_idx + ROW_ONE;
        end
`ifdef QFT_SEQ_ABS_EN
        S_ABS: begin
          if (!last_row) row_idx <= row_idx + ROW_ONE;
        end
        S_ABS_END: row_idx <= '0;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qft_seq_ctrl.sv
// Bench for qft_seq_ctrl: vector table of QFT runs with a scoreboard of expected
// update_state pulses, plus reset, abort-in-idle and ABS hand sequences.
module tb_qft_seq_ctrl;
  localparam int N        = 4;
  localparam int ROWS     = 4;
  localparam int MULT_LAT = 1;
  localparam int WIDTH    = $clog2(N);
  localparam int RW       = $clog2(ROWS);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             strt_qft = 1'b0;
  logic             strt_abs = 1'b0;
  logic             abort = 1'b0;
  logic [WIDTH:0]   n_terms = '0;
  logic             mult_ready = 1'b1;
  logic             w_en_mult, w_en_acc, clr_acc, w_en_abs, update_state, busy, done;
  logic [WIDTH:0]   sel_counter;
  logic [RW-1:0]    row_idx;

  qft_seq_ctrl #(.N(N), .ROWS(ROWS), .MULT_LAT(MULT_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .strt_qft(strt_qft), .strt_abs(strt_abs), .abort(abort),
    .n_terms(n_terms), .mult_ready(mult_ready), .w_en_mult(w_en_mult), .w_en_acc(w_en_acc),
    .clr_acc(clr_acc), .w_en_abs(w_en_abs), .update_state(update_state),
    .sel_counter(sel_counter), .row_idx(row_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int all_outs();
    return int'({w_en_mult, w_en_acc, clr_acc, w_en_abs, update_state, busy, done,
                 sel_counter, row_idx});
  endfunction

  typedef struct {
    logic [WIDTH:0] n_terms;
    int             exp_len;
    int             stall_at;
    int             stall_len;
    int             abort_at;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input int idx, input vec_t v);
    int cyc, done_cyc, n_mult, n_acc, n_clr, max_sel, len_l, upd, limit;
    logic [15:0] exp, got;
    len_l = 2 + v.exp_len * (MULT_LAT + 1);
    exp_q.delete();
    for (int r = 0; r < ROWS; r++) begin
      upd = len_l * (r + 1) + v.stall_len;
      if (v.abort_at == 0 || upd < v.abort_at) exp_q.push_back({8'(r), 8'(upd)});
    end
    limit = (v.abort_at != 0) ? v.abort_at + 6 : 120;
    n_mult = 0; n_acc = 0; n_clr = 0; max_sel = 0; done_cyc = 0; cyc = 0;
    @(negedge clk);
    strt_qft = 1'b1;
    strt_abs = 1'b1;
    n_terms  = v.n_terms;
    while (cyc < limit) begin
      @(negedge clk);
      cyc++;
      strt_qft   = (cyc == 5);
      strt_abs   = 1'b0;
      mult_ready = !(cyc >= v.stall_at && cyc < v.stall_at + v.stall_len);
      abort      = (v.abort_at != 0 && cyc == v.abort_at);
      #1;
      n_terms = clr_acc ? v.n_terms : (WIDTH+1)'($urandom_range(0, 7));
      if (w_en_mult) n_mult++;
      if (w_en_acc)  n_acc++;
      if (clr_acc)   n_clr++;
      if (int'(sel_counter) > max_sel) max_sel = int'(sel_counter);
      if (update_state) begin
        got = {8'(row_idx), 8'(cyc)};
        if (exp_q.size() == 0) check($sformatf("v%0d_upd_unexpected@%0d", idx, cyc), 1, 0);
        else begin
          exp = exp_q.pop_front();
          check($sformatf("v%0d_upd_row_cyc", idx), int'(got), int'(exp));
        end
      end
      if (done && done_cyc == 0) done_cyc = cyc;
      if (v.abort_at != 0 && cyc == v.abort_at + 1) check($sformatf("v%0d_busy_after_abort", idx), int'(busy), 0);
      if (done_cyc != 0 && cyc == done_cyc + 1) begin
        check($sformatf("v%0d_busy_after_done", idx), int'(busy), 0);
        break;
      end
    end
    abort = 1'b0; mult_ready = 1'b1; strt_qft = 1'b0;
    check($sformatf("v%0d_done_cycle", idx), done_cyc,
          (v.abort_at != 0) ? 0 : len_l * ROWS + v.stall_len);
    check($sformatf("v%0d_missed_updates", idx), exp_q.size(), 0);
    if (v.abort_at == 0) begin
      check($sformatf("v%0d_mult_cnt", idx), n_mult, ROWS * v.exp_len * MULT_LAT + v.stall_len);
      check($sformatf("v%0d_acc_cnt", idx), n_acc, ROWS * v.exp_len);
      check($sformatf("v%0d_clr_cnt", idx), n_clr, ROWS);
      check($sformatf("v%0d_max_sel", idx), max_sel, v.exp_len - 1);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{n_terms: 3'd4, exp_len: 4, stall_at: 0, stall_len: 0, abort_at: 0};
    vecs[1] = '{n_terms: 3'd2, exp_len: 2, stall_at: 0, stall_len: 0, abort_at: 0};
    vecs[2] = '{n_terms: 3'd0, exp_len: 4, stall_at: 0, stall_len: 0, abort_at: 0};
    vecs[3] = '{n_terms: 3'd7, exp_len: 4, stall_at: 0, stall_len: 0, abort_at: 0};
    vecs[4] = '{n_terms: 3'd1, exp_len: 1, stall_at: 0, stall_len: 0, abort_at: 0};
    vecs[5] = '{n_terms: 3'd4, exp_len: 4, stall_at: 4, stall_len: 3, abort_at: 0};
    vecs[6] = '{n_terms: 3'd4, exp_len: 4, stall_at: 0, stall_len: 0, abort_at: 15};
    vecs[7] = '{n_terms: 3'd4, exp_len: 4, stall_at: 0, stall_len: 0, abort_at: 10};

    // reset values
    repeat (2) @(negedge clk);
    check("reset_outputs", all_outs(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", all_outs(), 0);

    // abort while idle has no effect
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("abort_idle_busy", int'(busy), 0);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // reset asserted during MULT of row 2
    @(negedge clk);
    strt_qft = 1'b1; n_terms = 3'd4;
    @(negedge clk);
    strt_qft = 1'b0;
    repeat (21) @(negedge clk);
    #1;
    check("pre_reset_mult", int'(w_en_mult), 1);
    check("pre_reset_row", int'(row_idx), 2);
    rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", all_outs(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_outputs", all_outs(), 0);

    // ABS pass
    strt_abs = 1'b1;
    @(negedge clk);
    strt_abs = 1'b0;
`ifdef QFT_SEQ_ABS_EN
    for (int c = 1; c <= 4; c++) begin
      #1;
      check($sformatf("abs_wen_c%0d", c), int'(w_en_abs), 1);
      check($sformatf("abs_row_c%0d", c), int'(row_idx), c - 1);
      check($sformatf("abs_nodone_c%0d", c), int'(done || update_state), 0);
      @(negedge clk);
    end
    #1;
    check("abs_end_upd", int'(update_state), 1);
    check("abs_end_done", int'(done), 1);
    @(negedge clk);
    check("abs_idle_after", int'(busy), 0);
`else
    for (int c = 1; c <= 5; c++) begin
      #1;
      check($sformatf("noabs_quiet_c%0d", c), all_outs(), 0);
      @(negedge clk);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
